// File: rtl/cpu_clock_ctrl_if.sv
// Control/status bundle between the board-side sequencer and its user.
// The master side drives the requests and the slave side drives the clock and status.
interface cpu_clock_ctrl_if #(
  parameter int unsigned CNT_WIDTH = 8,
  parameter int unsigned CYC_WIDTH = 32
);
  logic [CNT_WIDTH-1:0] div_half;
  logic                 run;
  logic                 step;
  logic                 soft_reset;
  logic                 cpu_clk;
  logic                 cpu_clk_rise;
  logic                 cpu_reset;
  logic                 halted;
  logic [CYC_WIDTH-1:0] cycle_count;

  modport master (
    output div_half, run, step, soft_reset,
    input  cpu_clk, cpu_clk_rise, cpu_reset, halted, cycle_count
  );

  modport slave (
    input  div_half, run, step, soft_reset,
    output cpu_clk, cpu_clk_rise, cpu_reset, halted, cycle_count
  );
endinterface

// File: rtl/cpu_clock_ctrl.sv
// CPU clock divider and reset sequencer with run/halt/single-step control
// and a cycle counter of cpu_clk rising edges since the CPU left reset.
module cpu_clock_ctrl #(
  parameter int unsigned CNT_WIDTH    = 8,
  parameter int unsigned DEFAULT_HALF = 4,
  parameter int unsigned RST_HOLD     = 4,
  parameter int unsigned CYC_WIDTH    = 32
) (
  input  logic           CLK100MHZ,
  input  logic           reset,
  cpu_clock_ctrl_if.slave bus
);

  localparam int unsigned HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  typedef enum logic [1:0] {
    S_HOLD = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2,
    S_STEP = 2'd3
  } state_t;

  state_t               state_q, state_nxt;
  logic [CNT_WIDTH-1:0] hc_q, hc_nxt;
  logic [CNT_WIDTH-1:0] h_q, h_nxt;
  logic [CNT_WIDTH-1:0] div_eff;
  logic [HOLD_W-1:0]    hold_q, hold_nxt;
  logic [CYC_WIDTH-1:0] cyc_q, cyc_nxt;
  logic                 clk_q, clk_nxt;
  logic                 rise_q, rise_nxt;
  logic                 rst_q, rst_nxt;
  logic                 halted_q, halted_nxt;
  logic                 active, at_term, period_end, hold_done;

  // A zero half-period request would stall the divider, so it runs at /2 instead.
  assign div_eff    = (bus.div_half == '0) ? CNT_WIDTH'(1) : bus.div_half;
  assign active     = (state_q != S_HALT);
  assign at_term    = active && (hc_q == (h_q - CNT_WIDTH'(1)));
  assign period_end = at_term && clk_q;
  assign hold_done  = (state_q == S_HOLD) && period_end &&
                      (hold_q == HOLD_W'(RST_HOLD - 1));

  // State register
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) state_q <= S_HOLD;
    else       state_q <= state_nxt;
  end

  // Next-state: transitions only at period boundaries, except leaving HALT
  always_comb begin
    state_nxt = state_q;
    if (bus.soft_reset) begin
      state_nxt = S_HOLD;
    end else begin
      case (state_q)
        S_HOLD: if (hold_done) state_nxt = bus.run ? S_RUN : S_HALT;
        S_RUN:  if (period_end && !bus.run) state_nxt = S_HALT;
        S_HALT: begin
          if (bus.run)       state_nxt = S_RUN;
          else if (bus.step) state_nxt = S_STEP;
        end
        S_STEP: if (period_end) state_nxt = bus.run ? S_RUN : S_HALT;
        default: state_nxt = S_HOLD;
      endcase
    end
  end

  // Next values of the divider, reset-hold counter and registered outputs
  always_comb begin
    hc_nxt     = hc_q;
    h_nxt      = h_q;
    hold_nxt   = hold_q;
    cyc_nxt    = cyc_q;
    clk_nxt    = clk_q;
    rise_nxt   = 1'b0;
    rst_nxt    = rst_q;
    halted_nxt = (state_nxt == S_HALT);
    if (bus.soft_reset) begin
      hc_nxt   = '0;
      h_nxt    = div_eff;
      hold_nxt = '0;
      cyc_nxt  = '0;
      clk_nxt  = 1'b0;
      rst_nxt  = 1'b1;
    end else if (!active) begin
      hc_nxt  = '0;
      clk_nxt = 1'b0;
    end else if (at_term) begin
      hc_nxt   = '0;
      clk_nxt  = ~clk_q;
      rise_nxt = ~clk_q;
      if (!clk_q && state_q != S_HOLD) cyc_nxt = cyc_q + CYC_WIDTH'(1);
      if (clk_q) begin
        h_nxt = div_eff;
        if (state_q == S_HOLD) begin
          if (hold_done) begin
            rst_nxt  = 1'b0;
            hold_nxt = '0;
          end else begin
            hold_nxt = hold_q + HOLD_W'(1);
          end
        end
      end
    end else begin
      hc_nxt = hc_q + CNT_WIDTH'(1);
    end
  end

  // Datapath and output registers
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      hc_q     <= '0;
      h_q      <= CNT_WIDTH'(DEFAULT_HALF);
      hold_q   <= '0;
      cyc_q    <= '0;
      clk_q    <= 1'b0;
      rise_q   <= 1'b0;
      rst_q    <= 1'b1;
      halted_q <= 1'b0;
    end else begin
      hc_q     <= hc_nxt;
      h_q      <= h_nxt;
      hold_q   <= hold_nxt;
      cyc_q    <= cyc_nxt;
      clk_q    <= clk_nxt;
      rise_q   <= rise_nxt;
      rst_q    <= rst_nxt;
      halted_q <= halted_nxt;
    end
  end

  assign bus.cpu_clk      = clk_q;
  assign bus.cpu_clk_rise = rise_q;
  assign bus.cpu_reset    = rst_q;
  assign bus.halted       = halted_q;
  assign bus.cycle_count  = cyc_q;

endmodule

// File: doc/cpu_clock_ctrl.md
Name: cpu_clock_ctrl

Overview:
Parametrised clock-enable and reset sequencer for the soft processor, sitting between the board clock and the core. It generates a divided CPU clock with a programmable half-period and holds the CPU in reset for a fixed number of CPU periods after power-up. It adds run/halt/single-step control and a CPU cycle counter for debug and the 7-segment display.

Parameters:
CNT_WIDTH, 8, width of the half-period counter and the div_half input
DEFAULT_HALF, 4, half-period in fast cycles after reset (/8 divide)
RST_HOLD, 4, number of full cpu_clk periods cpu_reset is held
CYC_WIDTH, 32, width of cycle_count

Ports:
CLK100MHZ  input  1  board clock; all logic on its posedge
reset  input  1  asynchronous, active-high reset
div_half  input  CNT_WIDTH  requested half-period in fast cycles; 0 treated as 1
run  input  1  level: 1 = free-run, 0 = halt at next period boundary
step  input  1  one-cycle pulse: request one cpu_clk period while halted
soft_reset  input  1  one-cycle pulse: synchronous re-entry into reset hold
cpu_clk  output  1  divided CPU clock, registered
cpu_clk_rise  output  1  one-cycle strobe, high in each cycle cpu_clk is newly 1
cpu_reset  output  1  CPU reset, active-high, registered
halted  output  1  high while in HALT
cycle_count  output  CYC_WIDTH  cpu_clk rising edges since cpu_reset last fell

Behaviour:
- Reset values: cpu_clk=0, cpu_clk_rise=0, cpu_reset=1, halted=0, cycle_count=0. State=HOLD, half counter hc=0, hold counter=0, latched half H=DEFAULT_HALF.
- Period: a low half then a high half, each H fast cycles. When the clock is active, hc counts 0..H-1. When hc==H-1, cpu_clk toggles and hc returns to 0.
- Edge numbering: edge k is the k-th CLK100MHZ posedge after reset release. cpu_clk goes 1 after edge H and 0 after edge 2H. cpu_clk_rise is high only for the cycle after edge H, 3H, ...
- H reload: at each 1->0 toggle (period boundary), H is loaded with div_half, with 0 mapped to 1. div_half changes mid-period take effect on the next period only.
- States:
  - HOLD: clock active, cpu_reset=1. Counts completed periods. At the 1->0 toggle that ends period RST_HOLD, cpu_reset falls in the same registered update. Next state is RUN if run=1, otherwise HALT. Defaults: cpu_reset=0 after edge 32.
  - RUN: clock active. At each 1->0 toggle, if run=0 the next state is HALT, otherwise stay in RUN. Deasserting run mid-period never truncates the period.
  - HALT: cpu_clk=0, hc held at 0, halted=1. If run=1, go to RUN next cycle; hc starts counting the following cycle. Else if step=1, go to STEP.
  - STEP: exactly one full period (H low, H high). At its 1->0 toggle, go to RUN if run=1, otherwise HALT. step pulses during STEP are ignored, not queued.
- soft_reset: synchronous, from any state, with priority over run and step. Next cycle: state=HOLD, cpu_reset=1, cpu_clk=0, cpu_clk_rise=0, hc=0, hold counter=0, cycle_count=0, H=div_half (0->1).
- cycle_count: increments on each cpu_clk_rise when state is not HOLD. Wraps modulo 2^CYC_WIDTH. Rising edges inside HOLD are not counted.
- H=1: cpu_clk toggles every fast cycle (/2) and cpu_clk_rise is high every other cycle.
- Asynchronous reset mid-operation: all registers return to reset values immediately, with no glitch sequencing required. cpu_reset is high during and after reset.

Test Plan:
- Power-up with defaults, run=1: cpu_clk rises after edges 4, 12, 20, 28 and falls after 8, 16, 24, 32. cpu_reset=1 through edge 31, 0 after edge 32. cycle_count=1 after edge 36.
- Free-run, then div_half=2 applied mid-period at edge 38: the current period still ends at edge 40. cpu_clk then rises after 42 and falls after 44. Separately, div_half=0 gives a period of 2 fast cycles.
- run dropped at edge 37 (cpu_clk high): cpu_clk falls after edge 40 and halted=1. cpu_clk stays 0 for 50 edges and cycle_count is unchanged.
- While HALT, step pulsed at edge n with H=4: cpu_clk is 1 for edges n+4..n+7 and 0 after n+8, halted=1 again. cycle_count +1. A second step at n+2 has no effect.
- While RUN with cycle_count=5, soft_reset at edge m: cpu_reset=1, cpu_clk=0 and cycle_count=0 after edge m. The reset-hold sequence then repeats, with cpu_reset falling after m+32 (H=4).
- Async reset asserted mid high-half: all outputs return to their reset values without waiting for a CLK100MHZ edge. Reset release repeats the power-up timing.
